tt_um_micro_div_njp: RTL and testbench
======================================

TT_UM_MICRO_DIV_NJP -- requirements
Module: tt_um_micro_div_njp

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 The block SHALL have these ports, one per line:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; clock-enable for all state
- ui_in  input  8  dividend N[7:0], sampled on start
- uio_in  input  8  [3:0] divisor D, sampled on start; [4] start; [7:5] unused
- uo_out  output  8  result {R[3:0], Q[3:0]}
- uio_out  output  8  [5] busy; [6] done; [7] err; [4:0] driven 0
- uio_oe  output  8  constant 8'hE0

Function
REQ-003 The block SHALL compute 8-bit by 4-bit unsigned restoring division: Q = N/D, R = N mod D. This is the inverse of the 4x4 micro multiplier.
REQ-004 The FSM SHALL have four states, IDLE, CHECK, ITER and DONE, and SHALL advance only on clk edges where ena=1.
REQ-005 In IDLE or DONE, a rising edge with start=1 SHALL latch N and D, clear done and err, set busy, and enter CHECK.
REQ-006 In CHECK, if D==0 or N[7:4]>=D, the block SHALL set err=1, Q=4'hF, R=4'hF and enter DONE after 1 cycle.
REQ-007 In CHECK, for all other operands, the block SHALL load rem=N[7:4] (5-bit), the shift register=N[3:0] and the 2-bit counter=0, then enter ITER.
REQ-008 Each ITER cycle SHALL perform these steps:
- t = {rem[3:0], sh[3]}
- if t>=D: rem = t-D and qbit = 1; otherwise rem = t and qbit = 0
- sh = {sh[2:0], qbit}
- counter increments
REQ-009 The block SHALL leave ITER after exactly 4 cycles (counter wraps 3->0) and enter DONE.
REQ-010 Latency SHALL be 6 cycles from the start edge to done=1 on a normal operation, and 2 cycles on err.
REQ-011 In DONE, done SHALL be 1, busy SHALL be 0, and uo_out SHALL hold {R,Q} stable until the next accepted start.
REQ-012 A start pulse while busy (CHECK or ITER) SHALL be ignored, with no effect on the operation or the latched operands.
REQ-013 A start held high continuously SHALL re-trigger once per DONE->CHECK transition; no edge detection is applied.
REQ-014 uo_out SHALL be 0 outside DONE; intermediate values SHALL NOT be visible.
REQ-015 Arithmetic widths SHALL be as follows:
- rem is 5 bits wide, so t never overflows
- the final rem is always less than D and fits in 4 bits
REQ-016 When ena=0, all state SHALL hold and outputs SHALL hold their last values.

Reset
REQ-017 Asserting rst_n=0 SHALL asynchronously force the following:
- state = IDLE
- uo_out = 0, busy = 0, done = 0, err = 0
- all datapath registers = 0
REQ-018 A reset mid-operation SHALL abort the operation with no residual result. The first start after rst_n=1 SHALL behave as from a power-on IDLE.

Structure
REQ-019 A shared package tt_div_pkg SHALL hold the following:
- the state enum
- width constants N_W=8, D_W=4, Q_W=4
- CHECK-to-DONE latency constants
REQ-020 The shift/compare/subtract datapath SHALL be a single sub-module div_datapath, controlled by the FSM in the top.
REQ-021 uio_oe and uio_out[4:0] SHALL be constant drives.

Verification
REQ-022 N=225 (8'hE1), D=15 -> done at cycle 6, err=0, uo_out=8'h0F (R=0, Q=15).
REQ-023 N=100, D=7 -> uo_out=8'h2E (R=2, Q=14), err=0.
REQ-024 Error operands SHALL be checked:
- N=50, D=0 -> done at cycle 2, err=1, uo_out=8'hFF
- N=240, D=15 (overflow) -> err=1, uo_out=8'hFF
REQ-025 Start N=100, D=7, then pulse start with N=9, D=3 on cycle 3 -> second start ignored; result is 8'h2E.
REQ-026 Start N=225, D=15, then assert rst_n=0 during ITER -> outputs 0 immediately. After release with no start, done stays 0.
REQ-027 An exhaustive sweep of N=A*B+r (A,B in 1..15, r<B) SHALL return Q=A and R=r, with zero mismatches.

Source files
------------

// File: rtl/tt_div_pkg.sv
// Shared types and constants for the 8-by-4 restoring divider.
package tt_div_pkg;

    localparam int N_W = 8;
    localparam int D_W = 4;
    localparam int Q_W = 4;

    localparam int ITER_CYCLES  = 4;
    localparam int CHK2DONE_ERR = 1;
    localparam int CHK2DONE_OK  = ITER_CYCLES + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_ITER  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/div_datapath.sv
// Shift/compare/subtract datapath: one quotient bit per step, remainder in rem.
module div_datapath
    import tt_div_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [N_W-1:0] n_i,
    input  logic [D_W-1:0] d_i,
    output logic [Q_W-1:0] q_o,
    output logic [D_W-1:0] r_o,
    output logic           last_o
);

    logic [D_W:0]   rem_q, rem_d;
    logic [Q_W-1:0] sh_q, sh_d;
    logic [1:0]     cnt_q, cnt_d;
    logic [D_W:0]   t;
    logic           qbit;
    logic           unused_rem_msb;

    // The remainder stays below D, so its top bit never reaches t.
    assign t              = {rem_q[D_W-1:0], sh_q[Q_W-1]};
    assign qbit           = (t >= {1'b0, d_i});
    assign unused_rem_msb = rem_q[D_W];

    always_comb begin
        rem_d = rem_q;
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            rem_d = {1'b0, n_i[N_W-1:Q_W]};
            sh_d  = n_i[Q_W-1:0];
            cnt_d = 2'd0;
        end else if (step_i) begin
            rem_d = qbit ? (t - {1'b0, d_i}) : t;
            sh_d  = {sh_q[Q_W-2:0], qbit};
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            rem_q <= rem_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o    = sh_q;
    assign r_o    = rem_q[D_W-1:0];
    assign last_o = (cnt_q == 2'(ITER_CYCLES - 1));

endmodule

// File: rtl/tt_um_micro_div_njp.sv
// Micro divider top: FSM sequencing operand capture, overflow check and four ITER steps.
module tt_um_micro_div_njp
    import tt_div_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e         state_q, state_d;
    logic [N_W-1:0] n_q, n_d;
    logic [D_W-1:0] d_q, d_d;
    logic           err_q, err_d;
    logic           load, step;
    logic           start;
    logic           last;
    logic           in_done, busy;
    logic [Q_W-1:0] quot;
    logic [D_W-1:0] rmd;
    logic [2:0]     unused_uio;

    assign start      = uio_in[4];
    assign unused_uio = uio_in[7:5];

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        err_d   = err_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d     = ui_in;
                    d_d     = uio_in[D_W-1:0];
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                // A high nibble >= D means the quotient needs more than four bits.
                if (d_q == '0 || n_q[N_W-1:Q_W] >= d_q) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    load    = 1'b1;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                step = 1'b1;
                if (last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            err_q   <= err_d;
        end
    end

    div_datapath u_dp (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (ena),
        .load_i (load),
        .step_i (step),
        .n_i    (n_q),
        .d_i    (d_q),
        .q_o    (quot),
        .r_o    (rmd),
        .last_o (last)
    );

    // Result is only exposed in DONE; err forces the all-ones pattern.
    assign in_done = (state_q == S_DONE);
    assign busy    = (state_q == S_CHECK) || (state_q == S_ITER);
    assign uo_out  = in_done ? (err_q ? 8'hFF : {rmd, quot}) : 8'h00;
    assign uio_out = {err_q, in_done, busy, 5'b00000};
    assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_micro_div_njp.sv
// Self-checking bench for the micro divider against an arithmetic reference model.
module tb_tt_um_micro_div_njp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;

    tt_um_micro_div_njp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference: {err, R, Q} from plain integer division.
    function automatic logic [8:0] model(input logic [7:0] n, input logic [3:0] d);
        int q;
        int r;
        if (d == 4'd0) return {1'b1, 8'hFF};
        q = int'(n) / int'(d);
        r = int'(n) % int'(d);
        if (q > 15) return {1'b1, 8'hFF};
        return {1'b0, r[3:0], q[3:0]};
    endfunction

    // Start one operation and count cycles (start edge = 1) until done, bounded.
    task automatic run_op(input logic [7:0] n, input logic [3:0] d,
                          output int lat, output logic [7:0] res, output logic err);
        @(negedge clk);
        ui_in  = n;
        uio_in = {3'b000, 1'b1, d};
        @(negedge clk);
        uio_in[4] = 1'b0;
        lat = 1;
        while (uio_out[6] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res = uo_out;
        err = uio_out[7];
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uo_out: got %h expected 00", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out: got %h expected 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'hE0) begin
            errors++;
            $display("FAIL reset_uio_oe: got %h expected e0", uio_oe);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0] tn [4] = '{8'd225, 8'd100, 8'd50, 8'd240};
        logic [3:0] td [4] = '{4'd15, 4'd7, 4'd0, 4'd15};
        logic [7:0] tr [4] = '{8'h0F, 8'h2E, 8'hFF, 8'hFF};
        logic       te [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int         tl [4] = '{6, 6, 2, 2};
        int         lat;
        logic [7:0] res;
        logic       err;
        for (int i = 0; i < 4; i++) begin
            run_op(tn[i], td[i], lat, res, err);
            checks++;
            if (res !== tr[i] || err !== te[i] || lat != tl[i]) begin
                errors++;
                $display("FAIL directed_%0d: N=%0d D=%0d got res=%h err=%b lat=%0d expected res=%h err=%b lat=%0d",
                         i, tn[i], td[i], res, err, lat, tr[i], te[i], tl[i]);
            end
        end
    endtask

    task automatic test_random();
        int         lat;
        logic [7:0] res;
        logic       err;
        logic [7:0] n;
        logic [3:0] d;
        logic [8:0] exp;
        for (int i = 0; i < 60; i++) begin
            n   = 8'($urandom);
            d   = 4'($urandom);
            exp = model(n, d);
            run_op(n, d, lat, res, err);
            checks++;
            if (res !== exp[7:0] || err !== exp[8] || lat != (exp[8] ? 2 : 6)) begin
                errors++;
                $display("FAIL random: N=%0d D=%0d got res=%h err=%b lat=%0d expected res=%h err=%b lat=%0d",
                         n, d, res, err, lat, exp[7:0], exp[8], exp[8] ? 2 : 6);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        @(negedge clk);
        ui_in  = 8'd100;
        uio_in = {3'b000, 1'b1, 4'd7};
        @(negedge clk);
        uio_in[4] = 1'b0;
        @(negedge clk);
        ui_in  = 8'd9;
        uio_in = {3'b000, 1'b1, 4'd3};
        @(negedge clk);
        uio_in[4] = 1'b0;
        lat = 3;
        while (uio_out[6] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (uo_out !== 8'h2E || uio_out[7] !== 1'b0 || lat != 6) begin
            errors++;
            $display("FAIL busy_ignore: got res=%h err=%b lat=%0d expected res=2e err=0 lat=6",
                     uo_out, uio_out[7], lat);
        end
    endtask

    task automatic test_ena_hold();
        int   lat;
        logic held_ok;
        @(negedge clk);
        ui_in  = 8'd100;
        uio_in = {3'b000, 1'b1, 4'd7};
        @(negedge clk);
        uio_in[4] = 1'b0;
        @(negedge clk);
        lat = 2;
        ena = 1'b0;
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            lat++;
            if (uio_out !== 8'h20 || uo_out !== 8'h00) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            errors++;
            $display("FAIL ena_hold_busy: got uio_out=%h uo_out=%h expected 20/00 while ena=0",
                     uio_out, uo_out);
        end
        ena = 1'b1;
        while (uio_out[6] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (uo_out !== 8'h2E || lat != 11) begin
            errors++;
            $display("FAIL ena_hold_latency: got res=%h lat=%0d expected res=2e lat=11", uo_out, lat);
        end
        ena    = 1'b0;
        ui_in  = 8'd9;
        uio_in = {3'b000, 1'b1, 4'd3};
        repeat (3) @(negedge clk);
        checks++;
        if (uo_out !== 8'h2E || uio_out !== 8'h40) begin
            errors++;
            $display("FAIL ena_hold_done: got uo_out=%h uio_out=%h expected 2e/40", uo_out, uio_out);
        end
        uio_in[4] = 1'b0;
        ena = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (uo_out !== 8'h2E || uio_out !== 8'h40) begin
            errors++;
            $display("FAIL done_stable: got uo_out=%h uio_out=%h expected 2e/40", uo_out, uio_out);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        ui_in  = 8'd100;
        uio_in = {3'b000, 1'b1, 4'd7};
        @(negedge clk);
        lat = 1;
        while (uio_out[6] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (uo_out !== 8'h2E || lat != 6) begin
            errors++;
            $display("FAIL held_start_first: got res=%h lat=%0d expected res=2e lat=6", uo_out, lat);
        end
        ui_in  = 8'd9;
        uio_in = {3'b000, 1'b1, 4'd3};
        @(negedge clk);
        checks++;
        if (uio_out !== 8'h20 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL held_start_retrigger: got uio_out=%h uo_out=%h expected 20/00", uio_out, uo_out);
        end
        uio_in[4] = 1'b0;
        lat = 1;
        while (uio_out[6] !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (uo_out !== 8'h03 || lat != 6) begin
            errors++;
            $display("FAIL held_start_second: got res=%h lat=%0d expected res=03 lat=6", uo_out, lat);
        end
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [7:0] res;
        logic       err;
        @(negedge clk);
        ui_in  = 8'd225;
        uio_in = {3'b000, 1'b1, 4'd15};
        @(negedge clk);
        uio_in[4] = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_async: got uo_out=%h uio_out=%h expected 00/00", uo_out, uio_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (uio_out !== 8'h00 || uo_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_residual: got uo_out=%h uio_out=%h expected 00/00", uo_out, uio_out);
        end
        run_op(8'd100, 4'd7, lat, res, err);
        checks++;
        if (res !== 8'h2E || err !== 1'b0 || lat != 6) begin
            errors++;
            $display("FAIL reset_mid_restart: got res=%h err=%b lat=%0d expected res=2e err=0 lat=6",
                     res, err, lat);
        end
    endtask

    task automatic test_sweep();
        int         lat;
        logic [7:0] res;
        logic       err;
        logic [7:0] n;
        logic [7:0] exp;
        for (int b = 1; b <= 15; b++) begin
            for (int a = 1; a <= 15; a++) begin
                for (int r = 0; r < b; r++) begin
                    n   = 8'(a * b + r);
                    exp = {4'(r), 4'(a)};
                    run_op(n, 4'(b), lat, res, err);
                    checks++;
                    if (res !== exp || err !== 1'b0 || lat != 6) begin
                        errors++;
                        $display("FAIL sweep: N=%0d D=%0d got res=%h err=%b lat=%0d expected res=%h err=0 lat=6",
                                 n, b, res, err, lat, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_ena_hold();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
